// File: rtl/fpu_divider_iterative_if.sv
// Operand/result handshake bundle for fpu_divider_iterative.
// The divider sits on the slave side; the issuing stage is the master.
interface fpu_divider_iterative_if #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
);
  localparam int W = 1 + EXP_WIDTH + MAN_WIDTH;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic [4:0]   out_flags;

  modport master (
    output in_valid, in_a, in_b, in_mode, out_ready,
    input  in_ready, out_valid, out_result, out_flags
  );

  modport slave (
    input  in_valid, in_a, in_b, in_mode, out_ready,
    output in_ready, out_valid, out_result, out_flags
  );
endinterface

// File: rtl/fpu_divider_iterative.sv
// Multi-cycle IEEE-754-style divider: radix-2 restoring mantissa division,
// four rounding modes with G/R/S, special-case bypass, one op in flight.
module fpu_divider_iterative #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23
) (
  input  logic                  clk,
  input  logic                  rst,
  fpu_divider_iterative_if.slave bus
);
  localparam int E  = EXP_WIDTH;
  localparam int N  = MAN_WIDTH;
  localparam int W  = 1 + E + N;
  localparam int CW = $clog2(N + 4) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(N + 3);
  localparam logic [E+1:0]  BIAS     = {3'b000, {(E-1){1'b1}}};
  localparam logic [E+1:0]  EXP_ONES = {2'b00, {E{1'b1}}};
  localparam logic [E+1:0]  EXP_ONE  = {{(E+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;
  state_t state_q, state_n;

  logic         accept;
  logic [E-1:0] ea, eb;
  logic [N-1:0] ma, mb;
  logic         a_zero, a_inf, a_nan, b_zero, b_inf, b_nan, sign_n;
  logic         spec_n;
  logic [W-1:0] spec_res_n;
  logic [4:0]   spec_flags_n;

  logic         sign_q, spec_q;
  logic [1:0]   mode_q;
  logic [E+1:0] ediff_q;
  logic [W-1:0] spec_res_q;
  logic [4:0]   spec_flags_q;
  logic [N+1:0] rem_q, rem_sub, rem_next;
  logic [N:0]   div_q;
  logic [N+3:0] quo_q;
  logic [CW-1:0] cnt_q;
  logic         qbit;
  logic         out_valid_q;
  logic [W-1:0] result_q;
  logic [4:0]   flags_q;

  logic [N+2:0] quo_n;
  logic [E+1:0] exp_adj, exp_fin;
  logic [N-1:0] man_rnd;
  logic         g_bit, r_bit, s_bit, inexact, inc, carry;
  logic [W-1:0] rnd_res;
  logic [4:0]   rnd_flags;

  assign bus.in_ready   = (state_q == IDLE) & ~rst;
  assign accept         = bus.in_valid & bus.in_ready;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.out_flags  = flags_q;

  assign ea     = bus.in_a[W-2:N];
  assign eb     = bus.in_b[W-2:N];
  assign ma     = bus.in_a[N-1:0];
  assign mb     = bus.in_b[N-1:0];
  assign sign_n = bus.in_a[W-1] ^ bus.in_b[W-1];
  // Exponent zero (including denormals) is flushed to signed zero.
  assign a_zero = (ea == '0);
  assign b_zero = (eb == '0);
  assign a_inf  = (&ea) & ~(|ma);
  assign b_inf  = (&eb) & ~(|mb);
  assign a_nan  = (&ea) & (|ma);
  assign b_nan  = (&eb) & (|mb);

  always_comb begin
    spec_n       = 1'b1;
    spec_res_n   = '0;
    spec_flags_n = '0;
    if (a_nan | b_nan) begin
      spec_res_n = '1;
    end else if ((a_zero & b_zero) | (a_inf & b_inf)) begin
      spec_res_n   = '1;
      spec_flags_n = 5'b10000;
    end else if (a_inf) begin
      spec_res_n = {sign_n, {E{1'b1}}, {N{1'b0}}};
    end else if (b_zero) begin
      spec_res_n   = {sign_n, {E{1'b1}}, {N{1'b0}}};
      spec_flags_n = 5'b01000;
    end else if (b_inf | a_zero) begin
      spec_res_n = {sign_n, {(E+N){1'b0}}};
    end else begin
      spec_n = 1'b0;
    end
  end

  assign qbit     = (rem_q >= {1'b0, div_q});
  assign rem_sub  = qbit ? (rem_q - {1'b0, div_q}) : rem_q;
  assign rem_next = {rem_sub[N:0], 1'b0};

  always_comb begin
    quo_n     = quo_q[N+3] ? quo_q[N+2:0] : {quo_q[N+1:0], 1'b0};
    exp_adj   = quo_q[N+3] ? ediff_q : (ediff_q - EXP_ONE);
    g_bit     = quo_n[2];
    r_bit     = quo_n[1];
    s_bit     = quo_n[0] | (|rem_q);
    inexact   = g_bit | r_bit | s_bit;
    case (mode_q)
      2'd0:    inc = g_bit & (r_bit | s_bit | quo_n[3]);
      2'd1:    inc = sign_q & inexact;
      2'd2:    inc = ~sign_q & inexact;
      default: inc = 1'b0;
    endcase
    {carry, man_rnd} = {1'b0, quo_n[N+2:3]} + {{N{1'b0}}, inc};
    exp_fin   = exp_adj + {{(E+1){1'b0}}, carry};
    rnd_res   = {sign_q, exp_fin[E-1:0], man_rnd};
    rnd_flags = {4'b0000, inexact};
    if ($signed(exp_fin) >= $signed(EXP_ONES)) begin
      rnd_flags = 5'b00101;
      case (mode_q)
        2'd0:    rnd_res = {sign_q, {E{1'b1}}, {N{1'b0}}};
        2'd1:    rnd_res = sign_q ? {1'b1, {E{1'b1}}, {N{1'b0}}}
                                  : {1'b0, {(E-1){1'b1}}, 1'b0, {N{1'b1}}};
        2'd2:    rnd_res = sign_q ? {1'b1, {(E-1){1'b1}}, 1'b0, {N{1'b1}}}
                                  : {1'b0, {E{1'b1}}, {N{1'b0}}};
        default: rnd_res = {sign_q, {(E-1){1'b1}}, 1'b0, {N{1'b1}}};
      endcase
    end else if ($signed(exp_fin) <= $signed({(E+2){1'b0}})) begin
      rnd_res   = {sign_q, {(E+N){1'b0}}};
      rnd_flags = 5'b00011;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE:    if (accept) state_n = spec_n ? ROUND : DIVIDE;
      DIVIDE:  if (cnt_q == CNT_LAST) state_n = ROUND;
      ROUND:   state_n = DONE;
      DONE:    if (out_valid_q & bus.out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
      cnt_q       <= '0;
    end else begin
      if (accept) begin
        sign_q       <= sign_n;
        mode_q       <= bus.in_mode;
        ediff_q      <= {2'b00, ea} - {2'b00, eb} + BIAS;
        spec_q       <= spec_n;
        spec_res_q   <= spec_res_n;
        spec_flags_q <= spec_flags_n;
        rem_q        <= {2'b01, ma};
        div_q        <= {1'b1, mb};
        quo_q        <= '0;
        cnt_q        <= '0;
      end
      if (state_q == DIVIDE) begin
        quo_q <= {quo_q[N+2:0], qbit};
        rem_q <= rem_next;
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == ROUND) begin
        result_q <= spec_q ? spec_res_q : rnd_res;
        flags_q  <= spec_q ? spec_flags_q : rnd_flags;
      end
      // Valid lags DONE entry by one cycle and drops on the handshake edge.
      out_valid_q <= (state_q == DONE) & ~(out_valid_q & bus.out_ready);
    end
  end
endmodule

// File: tb/tb_fpu_divider_iterative.sv
// Scoreboard bench for fpu_divider_iterative: single- and double-precision
// instances, expectations queued at accept and checked at the output handshake.
module tb_fpu_divider_iterative;
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    string       tag;
    logic [63:0] res;
    logic [4:0]  flags;
    int          lat;
    int          acc;
  } exp_t;

  exp_t qs[$];
  exp_t qd[$];

  fpu_divider_iterative_if #(.EXP_WIDTH(8),  .MAN_WIDTH(23)) bs();
  fpu_divider_iterative_if #(.EXP_WIDTH(11), .MAN_WIDTH(52)) bd();

  fpu_divider_iterative #(.EXP_WIDTH(8), .MAN_WIDTH(23)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (bs)
  );

  fpu_divider_iterative #(.EXP_WIDTH(11), .MAN_WIDTH(52)) dut_d (
    .clk (clk),
    .rst (rst),
    .bus (bd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_exp(input bit dbl, input string tag, input logic [63:0] er,
                          input logic [4:0] ef, input int lat);
    exp_t e;
    e.tag = tag; e.res = er; e.flags = ef; e.lat = lat; e.acc = cyc;
    if (dbl) qd.push_back(e);
    else     qs.push_back(e);
  endtask

  task automatic score(input bit dbl, input logic [63:0] res, input logic [4:0] fl, input int rise);
    exp_t e;
    int   sz;
    sz = dbl ? qd.size() : qs.size();
    check_val("sb_pending", 64'(sz != 0), 64'd1);
    if (sz == 0) return;
    if (dbl) e = qd.pop_front();
    else     e = qs.pop_front();
    check_val({e.tag, "_res"},   res,             e.res);
    check_val({e.tag, "_flags"}, 64'(fl),         64'(e.flags));
    check_val({e.tag, "_lat"},   64'(rise - e.acc), 64'(e.lat));
  endtask

  // Entered at posedge+2; returns at posedge+2 after the accepting edge.
  task automatic send(input bit dbl, input string tag, input logic [63:0] a, input logic [63:0] b,
                      input logic [1:0] mode, input logic [63:0] er, input logic [4:0] ef, input int lat);
    logic rdy;
    if (dbl) begin
      bd.in_a = a; bd.in_b = b; bd.in_mode = mode; bd.in_valid = 1'b1;
    end else begin
      bs.in_a = a[31:0]; bs.in_b = b[31:0]; bs.in_mode = mode; bs.in_valid = 1'b1;
    end
    rdy = 1'b0;
    for (int n = 0; n < 300 && !rdy; n++) begin
      @(negedge clk);
      rdy = dbl ? bd.in_ready : bs.in_ready;
    end
    if (!rdy) begin
      check_val({tag, "_ready"}, 64'(rdy), 64'd1);
      bs.in_valid = 1'b0; bd.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    push_exp(dbl, tag, er, ef, lat);
    #1;
    if (dbl) begin
      bd.in_valid = 1'b0; bd.in_a = {$urandom, $urandom}; bd.in_b = {$urandom, $urandom};
    end else begin
      bs.in_valid = 1'b0; bs.in_a = $urandom; bs.in_b = $urandom;
    end
  endtask

  task automatic wait_drain();
    for (int n = 0; n < 400 && (qs.size() + qd.size()) != 0; n++) @(negedge clk);
    check_val("drain", 64'(qs.size() + qd.size()), 64'd0);
    step();
  endtask

  initial begin : mon_s
    logic ov_prev = 1'b0;
    int   rise = 0;
    forever begin
      @(negedge clk);
      if (bs.out_valid && !ov_prev) rise = cyc;
      ov_prev = bs.out_valid;
      if (bs.out_valid && bs.out_ready && !rst)
        score(1'b0, {32'h0, bs.out_result}, bs.out_flags, rise);
    end
  end

  initial begin : mon_d
    logic ov_prev = 1'b0;
    int   rise = 0;
    forever begin
      @(negedge clk);
      if (bd.out_valid && !ov_prev) rise = cyc;
      ov_prev = bd.out_valid;
      if (bd.out_valid && bd.out_ready && !rst)
        score(1'b1, bd.out_result, bd.out_flags, rise);
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    logic ov;
    logic seen;
    rst = 1'b1;
    bs.in_valid = 1'b0; bs.in_a = '0; bs.in_b = '0; bs.in_mode = '0; bs.out_ready = 1'b1;
    bd.in_valid = 1'b0; bd.in_a = '0; bd.in_b = '0; bd.in_mode = '0; bd.out_ready = 1'b1;

    repeat (2) @(negedge clk);
    check_val("rst_in_ready",  64'(bs.in_ready),  64'd0);
    check_val("rst_out_valid", 64'(bs.out_valid), 64'd0);
    check_val("rst_result",    64'(bs.out_result), 64'd0);
    check_val("rst_flags",     64'(bs.out_flags), 64'd0);
    check_val("rst_d_valid",   64'(bd.out_valid), 64'd0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check_val("rel_in_ready",   64'(bs.in_ready), 64'd1);
    check_val("rel_d_in_ready", 64'(bd.in_ready), 64'd1);
    step();

    send(0, "six_by_two",   64'h40C00000, 64'h40000000, 2'd0, 64'h40400000, 5'b00000, 29);
    send(0, "third_even",   64'h3F800000, 64'h40400000, 2'd0, 64'h3EAAAAAB, 5'b00001, 29);
    send(0, "third_up",     64'h3F800000, 64'h40400000, 2'd2, 64'h3EAAAAAB, 5'b00001, 29);
    send(0, "third_down",   64'h3F800000, 64'h40400000, 2'd1, 64'h3EAAAAAA, 5'b00001, 29);
    send(0, "third_zero",   64'h3F800000, 64'h40400000, 2'd3, 64'h3EAAAAAA, 5'b00001, 29);
    send(0, "neg_third_dn", 64'hBF800000, 64'h40400000, 2'd1, 64'hBEAAAAAB, 5'b00001, 29);
    send(0, "zero_zero",    64'h00000000, 64'h00000000, 2'd0, 64'hFFFFFFFF, 5'b10000, 2);
    send(0, "one_negzero",  64'h3F800000, 64'h80000000, 2'd0, 64'hFF800000, 5'b01000, 2);
    send(0, "nan_one",      64'h7FC00000, 64'h3F800000, 2'd0, 64'hFFFFFFFF, 5'b00000, 2);
    send(0, "inf_inf",      64'h7F800000, 64'hFF800000, 2'd0, 64'hFFFFFFFF, 5'b10000, 2);
    send(0, "inf_two",      64'h7F800000, 64'h40000000, 2'd0, 64'h7F800000, 5'b00000, 2);
    send(0, "negone_inf",   64'hBF800000, 64'h7F800000, 2'd0, 64'h80000000, 5'b00000, 2);
    send(0, "ovf_even",     64'h7F7FFFFF, 64'h3F000000, 2'd0, 64'h7F800000, 5'b00101, 29);
    send(0, "ovf_zero",     64'h7F7FFFFF, 64'h3F000000, 2'd3, 64'h7F7FFFFF, 5'b00101, 29);
    send(0, "ovf_up",       64'h7F7FFFFF, 64'h3F000000, 2'd2, 64'h7F800000, 5'b00101, 29);
    send(0, "ovf_down",     64'h7F7FFFFF, 64'h3F000000, 2'd1, 64'h7F7FFFFF, 5'b00101, 29);
    send(0, "novf_down",    64'hFF7FFFFF, 64'h3F000000, 2'd1, 64'hFF800000, 5'b00101, 29);
    send(0, "novf_up",      64'hFF7FFFFF, 64'h3F000000, 2'd2, 64'hFF7FFFFF, 5'b00101, 29);
    send(0, "unf",          64'h00800000, 64'h40000000, 2'd0, 64'h00000000, 5'b00011, 29);
    wait_drain();

    // Backpressure: hold the result, offer a second operand pair meanwhile.
    bs.out_ready = 1'b0;
    send(0, "bp_first", 64'h40C00000, 64'h40000000, 2'd0, 64'h40400000, 5'b00000, 29);
    ov = 1'b0;
    for (int n = 0; n < 100 && !ov; n++) begin
      @(negedge clk);
      ov = bs.out_valid;
    end
    check_val("bp_valid", 64'(ov), 64'd1);
    step();
    bs.in_a = 32'h3F800000; bs.in_b = 32'h40400000; bs.in_mode = 2'd0; bs.in_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check_val("bp_result",   64'(bs.out_result), 64'h40400000);
      check_val("bp_flags",    64'(bs.out_flags),  64'd0);
      check_val("bp_in_ready", 64'(bs.in_ready),   64'd0);
    end
    step();
    bs.out_ready = 1'b1;
    @(negedge clk);
    check_val("bp_hs_ready", 64'(bs.in_ready), 64'd0);
    @(negedge clk);
    check_val("bp_post_ready", 64'(bs.in_ready),  64'd1);
    check_val("bp_post_valid", 64'(bs.out_valid), 64'd0);
    @(posedge clk);
    #1;
    push_exp(0, "bp_second", 64'h3EAAAAAB, 5'b00001, 29);
    #1;
    bs.in_valid = 1'b0;
    wait_drain();

    // Reset during DIVIDE cycle 5 discards the operation.
    bs.in_a = 32'h40C00000; bs.in_b = 32'h40000000; bs.in_mode = 2'd0; bs.in_valid = 1'b1;
    @(negedge clk);
    check_val("rst_op_ready", 64'(bs.in_ready), 64'd1);
    @(posedge clk);
    #2;
    bs.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst = 1'b1;
    @(negedge clk);
    check_val("rstop_in_ready", 64'(bs.in_ready), 64'd0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check_val("rstop_ready_after", 64'(bs.in_ready),  64'd1);
    check_val("rstop_valid_after", 64'(bs.out_valid), 64'd0);
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | bs.out_valid;
    end
    check_val("rstop_no_result", 64'(seen), 64'd0);
    step();

    send(1, "dbl_third", 64'h3FF0000000000000, 64'h4008000000000000, 2'd0,
         64'h3FD5555555555555, 5'b00001, 58);
    send(1, "dbl_nan", 64'h7FF8000000000000, 64'h3FF0000000000000, 2'd0,
         64'hFFFFFFFFFFFFFFFF, 5'b00000, 2);
    wait_drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
